// File: rtl/ysyx_25030093_mem_arbiter.sv
// rtl/ysyx_25030093_mem_arbiter.sv - two-master round-robin memory arbiter with response watchdog
module ysyx_25030093_mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst,

   input  logic                ifu_req_valid,
   output logic                ifu_req_ready,
   input  logic [ADDR_W-1:0]   ifu_addr,
   output logic                ifu_rsp_valid,
   input  logic                ifu_rsp_ready,
   output logic [DATA_W-1:0]   ifu_rdata,
   output logic                ifu_rsp_err,

   input  logic                lsu_req_valid,
   output logic                lsu_req_ready,
   input  logic [ADDR_W-1:0]   lsu_addr,
   input  logic                lsu_wen,
   input  logic [DATA_W-1:0]   lsu_wdata,
   input  logic [DATA_W/8-1:0] lsu_wmask,
   output logic                lsu_rsp_valid,
   input  logic                lsu_rsp_ready,
   output logic [DATA_W-1:0]   lsu_rdata,
   output logic                lsu_rsp_err,

   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_wen,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wmask,
   input  logic                mem_rsp_valid,
   output logic                mem_rsp_ready,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic                mem_rsp_err
);

   localparam int MASK_W = DATA_W / 8;
   localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
   localparam logic WDOG_EN = (TIMEOUT != 0);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_RSP  = 2'd3
   } state_t;

   // owner / last_grant encoding: 0 = IFU, 1 = LSU
   state_t              state_q, state_d;
   logic                owner_q, owner_d;
   logic                last_grant_q, last_grant_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                wen_q, wen_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [MASK_W-1:0]   wmask_q, wmask_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                err_q, err_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic                grant_ifu;
   logic                grant_lsu;
   logic                owner_rsp_ready;

   // Grant decode in IDLE: a lone requester wins, a tie goes to the master not served last
   always_comb begin
      grant_ifu = 1'b0;
      grant_lsu = 1'b0;
      if (state_q == S_IDLE) begin
         if (lsu_req_valid && (!ifu_req_valid || !last_grant_q)) begin
            grant_lsu = 1'b1;
         end else if (ifu_req_valid) begin
            grant_ifu = 1'b1;
         end
      end
   end

   assign owner_rsp_ready = owner_q ? lsu_rsp_ready : ifu_rsp_ready;

   // Next-state logic: latch request, forward it, wait for memory (or the watchdog), hand back
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      addr_d       = addr_q;
      wen_d        = wen_q;
      wdata_d      = wdata_q;
      wmask_d      = wmask_q;
      rdata_d      = rdata_q;
      err_d        = err_q;
      cnt_d        = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (grant_lsu) begin
               owner_d = 1'b1;
               addr_d  = lsu_addr;
               wen_d   = lsu_wen;
               wdata_d = lsu_wdata;
               wmask_d = lsu_wmask;
               state_d = S_REQ;
            end else if (grant_ifu) begin
               // fetches are plain reads, so the write side is zeroed rather than left stale
               owner_d = 1'b0;
               addr_d  = ifu_addr;
               wen_d   = 1'b0;
               wdata_d = '0;
               wmask_d = '0;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (mem_req_ready) begin
               cnt_d   = '0;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (mem_rsp_valid) begin
               rdata_d = mem_rdata;
               err_d   = mem_rsp_err;
               state_d = S_RSP;
            end else if (WDOG_EN && (cnt_q == CNT_MAX)) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = S_RSP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_RSP: begin
            if (owner_rsp_ready) begin
               last_grant_d = owner_q;
               state_d      = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and latch registers; reset also drops any transaction in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b0;
         addr_q       <= '0;
         wen_q        <= 1'b0;
         wdata_q      <= '0;
         wmask_q      <= '0;
         rdata_q      <= '0;
         err_q        <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         addr_q       <= addr_d;
         wen_q        <= wen_d;
         wdata_q      <= wdata_d;
         wmask_q      <= wmask_d;
         rdata_q      <= rdata_d;
         err_q        <= err_d;
         cnt_q        <= cnt_d;
      end
   end

   assign ifu_req_ready = grant_ifu;
   assign lsu_req_ready = grant_lsu;

   assign mem_req_valid = (state_q == S_REQ);
   assign mem_addr      = addr_q;
   assign mem_wen       = wen_q;
   assign mem_wdata     = wdata_q;
   assign mem_wmask     = wmask_q;
   assign mem_rsp_ready = (state_q == S_WAIT);

   // Response data is steered to the owner only, so the other master never sees a stale word
   assign ifu_rsp_valid = (state_q == S_RSP) && !owner_q;
   assign lsu_rsp_valid = (state_q == S_RSP) &&  owner_q;
   assign ifu_rdata     = owner_q ? '0 : rdata_q;
   assign lsu_rdata     = owner_q ? rdata_q : '0;
   assign ifu_rsp_err   = !owner_q && err_q;
   assign lsu_rsp_err   =  owner_q && err_q;

endmodule

// File: tb/tb_ysyx_25030093_mem_arbiter.sv
// tb/tb_ysyx_25030093_mem_arbiter.sv - scoreboard bench for the two-master memory arbiter
module tb_ysyx_25030093_mem_arbiter;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready, ifu_rsp_err;
   logic [31:0] ifu_addr, ifu_rdata;
   logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid, lsu_rsp_ready, lsu_rsp_err;
   logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
   logic [3:0]  lsu_wmask;
   logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid, mem_rsp_ready, mem_rsp_err;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wmask;
   logic [31:0] rdata_key;

   typedef struct packed {
      logic        owner;
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

   rsp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   // memory returns a word derived from the address it was given
   assign mem_rdata = mem_addr ^ rdata_key;

   ysyx_25030093_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
      .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready),
      .ifu_rdata(ifu_rdata), .ifu_rsp_err(ifu_rsp_err),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
      .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
      .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready),
      .lsu_rdata(lsu_rdata), .lsu_rsp_err(lsu_rsp_err),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
      .mem_rdata(mem_rdata), .mem_rsp_err(mem_rsp_err)
   );

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      ifu_req_valid = 1'b0; ifu_addr = '0; ifu_rsp_ready = 1'b0;
      lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
      lsu_rsp_ready = 1'b0;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
      rdata_key = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
      #1;
      checks++;
      if ({ifu_req_ready, lsu_req_ready, mem_req_valid, mem_rsp_ready, ifu_rsp_valid, lsu_rsp_valid} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctrl got %b want 000000",
                  {ifu_req_ready, lsu_req_ready, mem_req_valid, mem_rsp_ready, ifu_rsp_valid, lsu_rsp_valid});
      end
      checks++;
      if ({mem_addr, mem_wen, mem_wdata, mem_wmask, ifu_rdata, lsu_rdata, ifu_rsp_err, lsu_rsp_err} !== '0) begin
         errors++;
         $display("FAIL reset_data got addr=%h wdata=%h mask=%h ifu_rdata=%h lsu_rdata=%h want all zero",
                  mem_addr, mem_wdata, mem_wmask, ifu_rdata, lsu_rdata);
      end
      ifu_req_valid = 1'b1;
      lsu_req_valid = 1'b1;
      #1;
      checks++;
      if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin
         errors++;
         $display("FAIL reset_first_tie got ifu/lsu ready=%b want 01", {ifu_req_ready, lsu_req_ready});
      end
      lsu_req_valid = 1'b0;
      #1;
      checks++;
      if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
         errors++;
         $display("FAIL reset_ifu_alone got ifu/lsu ready=%b want 10", {ifu_req_ready, lsu_req_ready});
      end
      ifu_req_valid = 1'b0;
      cyc();
   endtask

   task automatic test_lsu_store();
      rsp_t e;
      idle_inputs();
      rdata_key = 32'h1111_0000;
      lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0010; lsu_wen = 1'b1;
      lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
      mem_req_ready = 1'b1; lsu_rsp_ready = 1'b1;
      #1;
      checks++;
      if (lsu_req_ready !== 1'b1 || ifu_req_ready !== 1'b0) begin
         errors++;
         $display("FAIL store_accept got lsu/ifu ready=%b%b want 10", lsu_req_ready, ifu_req_ready);
      end
      e.owner = 1'b1; e.rdata = 32'h8000_0010 ^ 32'h1111_0000; e.err = 1'b0;
      exp_q.push_back(e);
      cyc();
      lsu_req_valid = 1'b0;
      checks++;
      if (mem_req_valid !== 1'b1 || mem_addr !== 32'h8000_0010 || mem_wen !== 1'b1 ||
          mem_wdata !== 32'hDEAD_BEEF || mem_wmask !== 4'hF) begin
         errors++;
         $display("FAIL store_mem_fields got v=%b a=%h w=%b d=%h m=%h want 1 80000010 1 deadbeef f",
                  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask);
      end
      cyc();
      checks++;
      if (mem_rsp_ready !== 1'b1 || mem_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL store_wait got rsp_ready=%b req_valid=%b want 1 0", mem_rsp_ready, mem_req_valid);
      end
      mem_rsp_valid = 1'b1;
      cyc();
      mem_rsp_valid = 1'b0;
      checks++;
      if (lsu_rsp_valid !== 1'b1 || ifu_rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL store_latency got lsu/ifu rsp_valid=%b%b at cycle 3 want 10", lsu_rsp_valid, ifu_rsp_valid);
      end
      if (exp_q.size() == 0) begin
         checks++; errors++;
         $display("FAIL store_scoreboard got empty queue want one entry");
      end else begin
         e = exp_q.pop_front();
         checks++;
         if (lsu_rdata !== e.rdata || lsu_rsp_err !== e.err) begin
            errors++;
            $display("FAIL store_rsp got rdata=%h err=%b want %h %b", lsu_rdata, lsu_rsp_err, e.rdata, e.err);
         end
      end
      cyc();
      checks++;
      if (lsu_rsp_valid !== 1'b0 || ifu_rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL store_done got lsu/ifu rsp_valid=%b%b want 00", lsu_rsp_valid, ifu_rsp_valid);
      end
   endtask

   task automatic test_round_robin();
      rsp_t       e;
      logic       exp_owner;
      logic [1:0] want_rdy;
      logic [1:0] want_rsp;
      idle_inputs();
      rst = 1'b1;
      ifu_req_valid = 1'b1; ifu_addr = 32'h0000_1000;
      lsu_req_valid = 1'b1; lsu_addr = 32'h0000_2000;
      mem_req_ready = 1'b1; mem_rsp_valid = 1'b1;
      ifu_rsp_ready = 1'b1; lsu_rsp_ready = 1'b1;
      rdata_key = 32'hCAFE_0000;
      cyc();
      rst = 1'b0;
      exp_owner = 1'b1;
      for (int c = 0; c < 16; c++) begin
         #1;
         want_rdy = ((c % 4) == 0) ? (exp_owner ? 2'b01 : 2'b10) : 2'b00;
         checks++;
         if ({ifu_req_ready, lsu_req_ready} !== want_rdy) begin
            errors++;
            $display("FAIL rr_ready c=%0d got ifu/lsu=%b want %b", c, {ifu_req_ready, lsu_req_ready}, want_rdy);
         end
         if ((c % 4) == 0) begin
            e.owner = exp_owner;
            e.rdata = (exp_owner ? 32'h0000_2000 : 32'h0000_1000) ^ 32'hCAFE_0000;
            e.err   = 1'b0;
            exp_q.push_back(e);
            exp_owner = ~exp_owner;
         end
         if ((c % 4) == 3) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL rr_scoreboard c=%0d got empty queue want entry", c);
            end else begin
               e = exp_q.pop_front();
               want_rsp = e.owner ? 2'b01 : 2'b10;
               checks++;
               if ({ifu_rsp_valid, lsu_rsp_valid} !== want_rsp ||
                   (e.owner ? lsu_rdata : ifu_rdata) !== e.rdata) begin
                  errors++;
                  $display("FAIL rr_rsp c=%0d got ifu/lsu valid=%b rdata=%h/%h want %b %h",
                           c, {ifu_rsp_valid, lsu_rsp_valid}, ifu_rdata, lsu_rdata, want_rsp, e.rdata);
               end
            end
         end
         cyc();
      end
      ifu_req_valid = 1'b0;
      lsu_req_valid = 1'b0;
      mem_rsp_valid = 1'b0;
      #1;
      checks++;
      if (exp_q.size() != 0 || ifu_req_ready !== 1'b0 || lsu_req_ready !== 1'b0) begin
         errors++;
         $display("FAIL rr_drain got queue=%0d ready=%b%b want 0 00", exp_q.size(), ifu_req_ready, lsu_req_ready);
      end
      exp_q.delete();
      cyc();
   endtask

   task automatic test_ifu_stall();
      rsp_t e;
      idle_inputs();
      rdata_key = 32'h8000_0413;
      ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000; ifu_rsp_ready = 1'b1;
      #1;
      checks++;
      if (ifu_req_ready !== 1'b1) begin
         errors++;
         $display("FAIL stall_accept got ifu_req_ready=%b want 1", ifu_req_ready);
      end
      e.owner = 1'b0; e.rdata = 32'h0000_0413; e.err = 1'b0;
      exp_q.push_back(e);
      cyc();
      ifu_req_valid = 1'b0;
      ifu_addr = 32'h1234_5678;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (mem_req_valid !== 1'b1 || mem_addr !== 32'h8000_0000 || mem_wen !== 1'b0 ||
             mem_wdata !== 32'h0 || mem_wmask !== 4'h0) begin
            errors++;
            $display("FAIL stall_hold i=%0d got v=%b a=%h w=%b d=%h m=%h want 1 80000000 0 0 0",
                     i, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask);
         end
         cyc();
      end
      mem_req_ready = 1'b1;
      cyc();
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1;
      cyc();
      mem_rsp_valid = 1'b0;
      if (exp_q.size() == 0) begin
         checks++; errors++;
         $display("FAIL stall_scoreboard got empty queue want entry");
      end else begin
         e = exp_q.pop_front();
         checks++;
         if (ifu_rsp_valid !== 1'b1 || lsu_rsp_valid !== 1'b0 || ifu_rdata !== e.rdata || ifu_rsp_err !== e.err) begin
            errors++;
            $display("FAIL stall_rsp got ifu/lsu valid=%b%b rdata=%h err=%b want 10 %h %b",
                     ifu_rsp_valid, lsu_rsp_valid, ifu_rdata, ifu_rsp_err, e.rdata, e.err);
         end
      end
      cyc();
   endtask

   task automatic test_rsp_hold();
      rsp_t e;
      idle_inputs();
      rdata_key = 32'h1234_0000;
      lsu_req_valid = 1'b1; lsu_addr = 32'h0000_0040; mem_req_ready = 1'b1;
      #1;
      checks++;
      if (lsu_req_ready !== 1'b1) begin
         errors++;
         $display("FAIL hold_accept got lsu_req_ready=%b want 1", lsu_req_ready);
      end
      cyc();
      lsu_req_valid = 1'b0;
      cyc();
      mem_rsp_valid = 1'b1; mem_rsp_err = 1'b1;
      e.owner = 1'b1; e.rdata = 32'h1234_0040; e.err = 1'b1;
      exp_q.push_back(e);
      cyc();
      mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
      rdata_key = 32'hFFFF_FFFF;
      ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
      if (exp_q.size() == 0) begin
         checks++; errors++;
         $display("FAIL hold_scoreboard got empty queue want entry");
      end else begin
         e = exp_q.pop_front();
      end
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (lsu_rsp_valid !== 1'b1 || lsu_rdata !== e.rdata || lsu_rsp_err !== e.err ||
             ifu_req_ready !== 1'b0 || lsu_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_stable i=%0d got v=%b rdata=%h err=%b rdy=%b%b want 1 %h %b 00",
                     i, lsu_rsp_valid, lsu_rdata, lsu_rsp_err, ifu_req_ready, lsu_req_ready, e.rdata, e.err);
         end
         cyc();
      end
      lsu_rsp_ready = 1'b1;
      #1;
      checks++;
      if (lsu_rsp_valid !== 1'b1 || ifu_req_ready !== 1'b0 || lsu_req_ready !== 1'b0) begin
         errors++;
         $display("FAIL hold_handshake got v=%b rdy=%b%b want 1 00", lsu_rsp_valid, ifu_req_ready, lsu_req_ready);
      end
      cyc();
      lsu_rsp_ready = 1'b0;
      #1;
      checks++;
      if (lsu_rsp_valid !== 1'b0 || ifu_req_ready !== 1'b1 || lsu_req_ready !== 1'b0) begin
         errors++;
         $display("FAIL hold_next_grant got v=%b ifu/lsu rdy=%b%b want 0 10", lsu_rsp_valid, ifu_req_ready, lsu_req_ready);
      end
      ifu_req_valid = 1'b0;
      lsu_req_valid = 1'b0;
      cyc();
   endtask

   task automatic test_timeout();
      rsp_t e;
      int   waited;
      logic rdy_ok;
      idle_inputs();
      rdata_key = 32'h5555_5555;
      lsu_req_valid = 1'b1; lsu_addr = 32'h0000_0080; mem_req_ready = 1'b1;
      #1;
      checks++;
      if (lsu_req_ready !== 1'b1) begin
         errors++;
         $display("FAIL wdog_accept got lsu_req_ready=%b want 1", lsu_req_ready);
      end
      e.owner = 1'b1; e.rdata = 32'h0; e.err = 1'b1;
      exp_q.push_back(e);
      cyc();
      lsu_req_valid = 1'b0;
      cyc();
      mem_req_ready = 1'b0;
      waited = 0;
      rdy_ok = 1'b1;
      while (lsu_rsp_valid !== 1'b1 && waited < 30) begin
         if (mem_rsp_ready !== 1'b1) rdy_ok = 1'b0;
         cyc();
         waited++;
      end
      checks++;
      if (waited != TO + 1 || !rdy_ok) begin
         errors++;
         $display("FAIL wdog_latency got %0d cycles (rsp_ready held=%b) want %0d 1", waited, rdy_ok, TO + 1);
      end
      if (exp_q.size() == 0) begin
         checks++; errors++;
         $display("FAIL wdog_scoreboard got empty queue want entry");
      end else begin
         e = exp_q.pop_front();
         checks++;
         if (lsu_rdata !== e.rdata || lsu_rsp_err !== e.err || ifu_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL wdog_rsp got rdata=%h err=%b ifu_v=%b want %h %b 0",
                     lsu_rdata, lsu_rsp_err, ifu_rsp_valid, e.rdata, e.err);
         end
      end
      lsu_rsp_ready = 1'b1;
      cyc();
      lsu_rsp_ready = 1'b0;
      checks++;
      if ({mem_req_valid, mem_rsp_ready, ifu_rsp_valid, lsu_rsp_valid} !== 4'b0) begin
         errors++;
         $display("FAIL wdog_idle got %b want 0000", {mem_req_valid, mem_rsp_ready, ifu_rsp_valid, lsu_rsp_valid});
      end
   endtask

   task automatic test_reset_mid();
      rsp_t e;
      idle_inputs();
      rdata_key = 32'h0F0F_0000;
      lsu_req_valid = 1'b1; lsu_addr = 32'h0000_0300; lsu_wen = 1'b1;
      lsu_wdata = 32'hA5A5_A5A5; lsu_wmask = 4'h3; mem_req_ready = 1'b1;
      cyc();
      lsu_req_valid = 1'b0;
      cyc();
      mem_req_ready = 1'b0;
      checks++;
      if (mem_rsp_ready !== 1'b1) begin
         errors++;
         $display("FAIL rmid_wait got mem_rsp_ready=%b want 1", mem_rsp_ready);
      end
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      checks++;
      if ({mem_req_valid, mem_rsp_ready, ifu_rsp_valid, lsu_rsp_valid} !== 4'b0 || mem_addr !== 32'h0) begin
         errors++;
         $display("FAIL rmid_abort got valids=%b mem_addr=%h want 0000 0",
                  {mem_req_valid, mem_rsp_ready, ifu_rsp_valid, lsu_rsp_valid}, mem_addr);
      end
      mem_rsp_valid = 1'b1;
      lsu_rsp_ready = 1'b1;
      ifu_rsp_ready = 1'b1;
      cyc();
      cyc();
      checks++;
      if ({mem_rsp_ready, ifu_rsp_valid, lsu_rsp_valid} !== 3'b0) begin
         errors++;
         $display("FAIL rmid_late_rsp got %b want 000", {mem_rsp_ready, ifu_rsp_valid, lsu_rsp_valid});
      end
      mem_rsp_valid = 1'b0;
      ifu_req_valid = 1'b1; ifu_addr = 32'h0000_0500; mem_req_ready = 1'b1;
      #1;
      checks++;
      if (ifu_req_ready !== 1'b1) begin
         errors++;
         $display("FAIL rmid_new_accept got ifu_req_ready=%b want 1", ifu_req_ready);
      end
      e.owner = 1'b0; e.rdata = 32'h0000_0500 ^ 32'h0F0F_0000; e.err = 1'b0;
      exp_q.push_back(e);
      cyc();
      ifu_req_valid = 1'b0;
      cyc();
      mem_rsp_valid = 1'b1;
      cyc();
      mem_rsp_valid = 1'b0;
      if (exp_q.size() == 0) begin
         checks++; errors++;
         $display("FAIL rmid_scoreboard got empty queue want entry");
      end else begin
         e = exp_q.pop_front();
         checks++;
         if (ifu_rsp_valid !== 1'b1 || ifu_rdata !== e.rdata || ifu_rsp_err !== e.err || lsu_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rmid_new_rsp got ifu_v=%b rdata=%h err=%b lsu_v=%b want 1 %h %b 0",
                     ifu_rsp_valid, ifu_rdata, ifu_rsp_err, lsu_rsp_valid, e.rdata, e.err);
         end
      end
      cyc();
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      test_reset();
      test_lsu_store();
      test_round_robin();
      test_ifu_stall();
      test_rsp_hold();
      test_timeout();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got no finish want finish before 200000");
      $fatal(1);
   end

endmodule

// File: doc/ysyx_25030093_mem_arbiter.md
# ysyx_25030093_mem_arbiter

Two-master, one-slave memory arbiter sharing the core's single memory port between the instruction fetch unit (IFU) and the load/store unit (LSU). Accepts one request at a time from either master over valid/ready handshakes, forwards it to memory, waits for the response, and returns it to the owning master. Round-robin grant on contention, one outstanding transaction, and a watchdog that converts a hung memory response into an error response. Sits between IFU/LSU and the memory/bus bridge.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; write mask is DATA_W/8 bits
- TIMEOUT, 255, max cycles in WAIT before error response; 0 disables watchdog
- clk  in  1  clock, all logic on posedge
- rst  in  1  reset, synchronous, active-high
- ifu_req_valid / ifu_req_ready  in / out  1  IFU request handshake (read-only master)
- ifu_addr  in  ADDR_W  IFU fetch address
- ifu_rsp_valid / ifu_rsp_ready  out / in  1  IFU response handshake
- ifu_rdata  out  DATA_W  fetched word; ifu_rsp_err  out  1  error flag
- lsu_req_valid / lsu_req_ready  in / out  1  LSU request handshake
- lsu_addr  in  ADDR_W; lsu_wen  in  1 (1 = store); lsu_wdata  in  DATA_W; lsu_wmask  in  DATA_W/8
- lsu_rsp_valid / lsu_rsp_ready  out / in  1  LSU response handshake
- lsu_rdata  out  DATA_W; lsu_rsp_err  out  1
- mem_req_valid / mem_req_ready  out / in  1  memory request handshake
- mem_addr  out  ADDR_W; mem_wen  out  1; mem_wdata  out  DATA_W; mem_wmask  out  DATA_W/8
- mem_rsp_valid / mem_rsp_ready  in / out  1  memory response handshake
- mem_rdata  in  DATA_W; mem_rsp_err  in  1

## Operation
- States: IDLE, REQ, WAIT, RSP. Registers: state, owner (0 = IFU, 1 = LSU), last_grant, latched addr/wen/wdata/wmask, latched rdata/err, watchdog counter.
- IDLE: grant = sole requester; if both are valid, grant the master opposite last_grant. Only the granted master sees req_ready = 1; the other sees 0. On handshake: latch fields, set owner, go to REQ. IFU requests latch wen = 0, wmask = 0, wdata = 0.
- REQ: mem_req_valid = 1 with the latched fields, held stable. On mem_req_ready go to WAIT and clear the counter.
- WAIT: mem_rsp_ready = 1. On mem_rsp_valid latch mem_rdata/mem_rsp_err and go to RSP. Otherwise increment the counter. When the counter reaches TIMEOUT (TIMEOUT ≠ 0), latch rdata = 0, err = 1, go to RSP.
- RSP: owner's rsp_valid = 1 with latched rdata/err, held stable. On the owner's rsp_ready: last_grant <= owner, go to IDLE. The non-owner's rsp_valid stays 0.
- mem_rsp_valid outside WAIT is ignored (mem_rsp_ready = 0). A req_valid dropped before handshake has no effect.

## Timing
- Reset: state = IDLE, last_grant = IFU (LSU wins the first tie), counter = 0, latched data = 0. All *_ready and *_valid outputs are 0 except in IDLE, where req_ready follows the grant logic. All data outputs are 0.
- rst mid-transaction aborts it: no response is delivered to either master, and the memory handshake is dropped.
- req_ready is combinational from req_valid and state. All other outputs are registered-state decodes.
- Minimum latency, with mem_req_ready high and the response the next cycle: accept at cycle 0, mem_req_valid at cycle 1, mem_rsp_valid at cycle 2, rsp_valid at cycle 3.
- Back-to-back throughput: at most one transaction per 4 cycles. A new request cannot be accepted in the same cycle as the RSP handshake.
- Watchdog: rsp_valid with err = 1 appears TIMEOUT+1 cycles after entering WAIT.

## Test plan
- LSU alone, store addr 0x8000_0010, wdata 0xDEAD_BEEF, wmask 0xF → mem sees exactly those fields with wen = 1. lsu_rsp_valid 3 cycles after accept; ifu_rsp_valid never rises.
- Both masters request every cycle from reset → grants alternate LSU, IFU, LSU, IFU. The idle master's req_ready stays 0 throughout.
- IFU fetch 0x8000_0000 with memory stalling mem_req_ready for 5 cycles → mem_addr/mem_req_valid stable all 5 cycles. ifu_rdata = mem_rdata (0x0000_0413); mem_wen = 0.
- Owner holds rsp_ready = 0 for 4 cycles → rsp_valid and rdata held stable. No new request is accepted until the response handshake.
- TIMEOUT = 8, memory never responds → lsu_rsp_valid with err = 1 and rdata = 0 at 9 cycles after entering WAIT. Arbiter returns to IDLE.
- rst asserted in WAIT → next cycle state is IDLE and all valids are 0. A late mem_rsp_valid is ignored. A subsequent request completes normally.
